// File: rtl/sms_wired_line_rx_if.sv
// rtl/sms_wired_line_rx_if.sv - snapshot event port (valid/data/ack) for the SMS wired-line receiver
interface sms_wired_line_rx_if #(
   parameter int WIDTH = 4
);
   logic             evt_valid;
   logic [WIDTH-1:0] evt_data;
   logic             evt_ack;

   modport master (
      output evt_valid,
      output evt_data,
      input  evt_ack
   );

   modport slave (
      input  evt_valid,
      input  evt_data,
      output evt_ack
   );
endinterface

// File: rtl/sms_wired_line_rx.sv
// rtl/sms_wired_line_rx.sv - synchronize, glitch-filter and edge-detect open-collector SMS lines, post changes as snapshots
// Optional undriven-net flag output float_o: define SMS_RX_FLOAT_DETECT_EN
module sms_wired_line_rx #(
   parameter int WIDTH         = 4,
   parameter int FILTER_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       line_i,
   output logic [WIDTH-1:0]       level_o,
   output logic [WIDTH-1:0]       rise_o,
   output logic [WIDTH-1:0]       fall_o,
   sms_wired_line_rx_if.master    evt,
   output logic                   overrun_o,
   input  logic                   ovr_clr
`ifdef SMS_RX_FLOAT_DETECT_EN
   ,
   output logic [WIDTH-1:0]       float_o
`endif
);

   localparam logic [7:0] FILTER_LAST = 8'(FILTER_CYCLES - 1);

   logic [WIDTH-1:0] line_bit;
   logic [WIDTH-1:0] sync_1;
   logic [WIDTH-1:0] sync_q;
   logic [7:0]       cnt_q [WIDTH];
   logic [7:0]       cnt_d [WIDTH];

   logic [WIDTH-1:0] level_d;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;
   logic             change;

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             ovr_d;
   logic             ovr_set;

   // A floating or unknown line reads as the pull-up level; only a hard 0 is a 0.
   always_comb begin
      line_bit = '1;
      for (int i = 0; i < WIDTH; i++) begin
         line_bit[i] = (line_i[i] === 1'b0) ? 1'b0 : 1'b1;
      end
   end

   always_comb begin
      level_d = level_o;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = 8'd0;
         if (sync_q[i] != level_o[i]) begin
            if (cnt_q[i] == FILTER_LAST) begin
               level_d[i] = sync_q[i];
               rise_d[i]  = sync_q[i];
               fall_d[i]  = ~sync_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
      change = |(level_d ^ level_o);
   end

   // An ack on the same edge as a change frees the slot, so the new snapshot lands without a bubble.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovr_set = 1'b0;
      if (change) begin
         if (!valid_q || evt.evt_ack) begin
            valid_d = 1'b1;
            data_d  = level_d;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (evt.evt_ack) begin
         valid_d = 1'b0;
      end
      ovr_d = ovr_set | (overrun_o & ~ovr_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1    <= '1;
         sync_q    <= '1;
         level_o   <= '1;
         rise_o    <= '0;
         fall_o    <= '0;
         valid_q   <= 1'b0;
         data_q    <= '1;
         overrun_o <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= 8'd0;
         end
      end else begin
         sync_1    <= line_bit;
         sync_q    <= sync_1;
         level_o   <= level_d;
         rise_o    <= rise_d;
         fall_o    <= fall_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         overrun_o <= ovr_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_data  = data_q;

`ifdef SMS_RX_FLOAT_DETECT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         float_o <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            float_o[i] <= (line_i[i] === 1'bz);
         end
      end
   end
`endif

endmodule

// File: tb/tb_sms_wired_line_rx.sv
// tb/tb_sms_wired_line_rx.sv - cycle-table and directed-sequence bench for sms_wired_line_rx (WIDTH=4, FILTER_CYCLES=3)
module tb_sms_wired_line_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ovr_clr = 1'b0;
   logic [3:0] lz = 4'h0;
   logic [3:0] lv = 4'h0;
   wire  [3:0] line;
   logic [3:0] level;
   logic [3:0] rise;
   logic [3:0] fall;
   logic       overrun;
`ifdef SMS_RX_FLOAT_DETECT_EN
   logic [3:0] float_flags;
`endif

   int tests = 0;
   int fails = 0;

   sms_wired_line_rx_if #(.WIDTH(4)) evt_if ();

   // Open-collector lines: a released bit floats and is pulled up.
   for (genvar b = 0; b < 4; b++) begin : g_line
      assign line[b] = lz[b] ? 1'bz : lv[b];
      pullup pu (line[b]);
   end

   sms_wired_line_rx #(.WIDTH(4), .FILTER_CYCLES(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line),
      .level_o   (level),
      .rise_o    (rise),
      .fall_o    (fall),
      .evt       (evt_if),
      .overrun_o (overrun),
      .ovr_clr   (ovr_clr)
`ifdef SMS_RX_FLOAT_DETECT_EN
      ,
      .float_o   (float_flags)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       ack;
      logic       clr;
      logic [3:0] lz;
      logic [3:0] lv;
      logic [3:0] level;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       valid;
      logic [3:0] data;
      logic       ovr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int n, input logic r, input logic a, input logic c,
                      input logic [3:0] z, input logic [3:0] v,
                      input logic [3:0] lev, input logic [3:0] ri, input logic [3:0] fa,
                      input logic va, input logic [3:0] da, input logic ov);
      vec_t e;
      e.rst = r; e.ack = a; e.clr = c; e.lz = z; e.lv = v;
      e.level = lev; e.rise = ri; e.fall = fa; e.valid = va; e.data = da; e.ovr = ov;
      for (int k = 0; k < n; k++) vecs.push_back(e);
   endtask

   task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int idx, input logic [3:0] lev,
                            input logic [3:0] ri, input logic [3:0] fa, input logic va,
                            input logic [3:0] da, input logic ov);
      chk({tag, ".level"},   idx, level, lev);
      chk({tag, ".rise"},    idx, rise, ri);
      chk({tag, ".fall"},    idx, fall, fa);
      chk({tag, ".valid"},   idx, {3'b0, evt_if.evt_valid}, {3'b0, va});
      chk({tag, ".data"},    idx, evt_if.evt_data, da);
      chk({tag, ".overrun"}, idx, {3'b0, overrun}, {3'b0, ov});
   endtask

   task automatic drive(input logic r, input logic a, input logic c, input logic [3:0] z, input logic [3:0] v);
      rst = r; evt_if.evt_ack = a; ovr_clr = c; lz = z; lv = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      evt_if.evt_ack = 1'b0;

      //   n  rst ack clr lz    lv   | level rise  fall valid data ovr
      add(2, 1, 0, 0, 4'h0, 4'h0,   4'hF, 4'h0, 4'h0, 0, 4'hF, 0);
      add(1, 0, 0, 0, 4'h0, 4'hF,   4'hF, 4'h0, 4'h0, 0, 4'hF, 0);
      add(4, 0, 0, 0, 4'h0, 4'hE,   4'hF, 4'h0, 4'h0, 0, 4'hF, 0);
      add(1, 0, 0, 0, 4'h0, 4'hE,   4'hE, 4'h0, 4'h1, 1, 4'hE, 0);
      add(1, 0, 0, 0, 4'h0, 4'hE,   4'hE, 4'h0, 4'h0, 1, 4'hE, 0);
      add(4, 0, 0, 0, 4'h0, 4'hA,   4'hE, 4'h0, 4'h0, 1, 4'hE, 0);
      add(1, 0, 0, 0, 4'h0, 4'hA,   4'hA, 4'h0, 4'h4, 1, 4'hE, 1);
      add(1, 0, 0, 1, 4'h0, 4'hA,   4'hA, 4'h0, 4'h0, 1, 4'hE, 0);
      add(1, 0, 1, 0, 4'h0, 4'hA,   4'hA, 4'h0, 4'h0, 0, 4'hE, 0);
      add(1, 0, 1, 0, 4'h0, 4'hA,   4'hA, 4'h0, 4'h0, 0, 4'hE, 0);
      add(2, 0, 0, 0, 4'h0, 4'h8,   4'hA, 4'h0, 4'h0, 0, 4'hE, 0);
      add(4, 0, 0, 0, 4'h2, 4'h8,   4'hA, 4'h0, 4'h0, 0, 4'hE, 0);
      add(4, 0, 0, 0, 4'hE, 4'h0,   4'hA, 4'h0, 4'h0, 0, 4'hE, 0);
      add(1, 0, 0, 0, 4'hE, 4'h0,   4'hE, 4'h4, 4'h0, 1, 4'hE, 0);
      add(5, 0, 0, 0, 4'h0, 4'hE,   4'hE, 4'h0, 4'h0, 1, 4'hE, 0);
      add(4, 0, 0, 0, 4'h0, 4'h6,   4'hE, 4'h0, 4'h0, 1, 4'hE, 0);
      add(1, 0, 1, 0, 4'h0, 4'h6,   4'h6, 4'h0, 4'h8, 1, 4'h6, 0);
      add(1, 0, 0, 0, 4'h0, 4'h6,   4'h6, 4'h0, 4'h0, 1, 4'h6, 0);
      add(1, 0, 1, 0, 4'h0, 4'h6,   4'h6, 4'h0, 4'h0, 0, 4'h6, 0);
      add(4, 0, 0, 0, 4'h0, 4'hF,   4'h6, 4'h0, 4'h0, 0, 4'h6, 0);
      add(1, 0, 0, 0, 4'h0, 4'hF,   4'hF, 4'h9, 4'h0, 1, 4'hF, 0);
      add(1, 0, 1, 0, 4'h0, 4'hF,   4'hF, 4'h0, 4'h0, 0, 4'hF, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ack, vecs[i].clr, vecs[i].lz, vecs[i].lv);
         check_all("vec", i, vecs[i].level, vecs[i].rise, vecs[i].fall,
                   vecs[i].valid, vecs[i].data, vecs[i].ovr);
      end

      // Pending snapshot of all-0, then a second change with ovr_clr on the same edge: set wins.
      for (int k = 0; k < 4; k++) drive(0, 0, 0, 4'h0, 4'h0);
      check_all("seqa", 0, 4'hF, 4'h0, 4'h0, 0, 4'hF, 0);
      drive(0, 0, 0, 4'h0, 4'h0);
      check_all("seqa", 1, 4'h0, 4'h0, 4'hF, 1, 4'h0, 0);
      for (int k = 0; k < 4; k++) drive(0, 0, 0, 4'h0, 4'hF);
      drive(0, 0, 1, 4'h0, 4'hF);
      check_all("seqa", 2, 4'hF, 4'hF, 4'h0, 1, 4'h0, 1);

      // Reset in the middle of a filter run with an event and overrun pending.
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 4'h0, 4'h0);
      check_all("seqb", 0, 4'hF, 4'h0, 4'h0, 1, 4'h0, 1);
      drive(1, 0, 0, 4'h0, 4'h0);
      check_all("seqb", 1, 4'hF, 4'h0, 4'h0, 0, 4'hF, 0);
      for (int k = 0; k < 4; k++) drive(0, 0, 0, 4'h0, 4'h0);
      check_all("seqb", 2, 4'hF, 4'h0, 4'h0, 0, 4'hF, 0);
      drive(0, 0, 0, 4'h0, 4'h0);
      check_all("seqb", 3, 4'h0, 4'h0, 4'hF, 1, 4'h0, 0);
      drive(0, 0, 0, 4'h0, 4'h0);
      check_all("seqb", 4, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
